fir_filter: RTL

Parametrised, pipelined FIR filter for the streaming datapath. It is the next generation of the fixed filter block and generalises it in four ways:
- configurable sample width, tap count and coefficient width
- run-time coefficient loading
- valid/ready backpressure on both sides
- optional input parity checking

It sits between an upstream valid/parity sample source and a downstream consumer, and keeps the same x_*/y_* stream naming.

---
 rtl/fir_filter.sv | 138 +++++++++++++
 1 files changed

// File: rtl/fir_filter.sv
// Pipelined FIR filter: delay line -> registered products -> saturating shifted sum, valid/ready on both sides.
// Optional input parity checking is enabled by defining FIR_PARITY_CHECK_EN.
module fir_filter #(
   parameter int DATA_WIDTH = 16,
   parameter int TAPS       = 4,
   parameter int COEF_WIDTH = 8,
   parameter int SHIFT      = 0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clear,
   input  logic [DATA_WIDTH-1:0]   x_data,
   input  logic                    x_valid,
   input  logic                    x_parity,
   output logic                    x_ready,
   output logic [DATA_WIDTH-1:0]   y_data,
   output logic                    y_valid,
   output logic                    y_parity,
   input  logic                    y_ready,
   input  logic                    coef_wr,
   input  logic [$clog2(TAPS)-1:0] coef_idx,
   input  logic [COEF_WIDTH-1:0]   coef_data,
   output logic                    parity_err
);

   localparam int IDX_W  = $clog2(TAPS);
   localparam int PROD_W = DATA_WIDTH + COEF_WIDTH;
   localparam int SUM_W  = PROD_W + IDX_W;
   localparam logic [SUM_W-1:0] SAT_MAX = {{(SUM_W-DATA_WIDTH){1'b0}}, {DATA_WIDTH{1'b1}}};

   logic [DATA_WIDTH-1:0] tap      [TAPS];
   logic [DATA_WIDTH-1:0] tap_next [TAPS];
   logic [COEF_WIDTH-1:0] coef     [TAPS];
   logic [PROD_W-1:0]     prod     [TAPS];
   logic                  s1_valid;
   logic                  en;
   logic                  accept;
   logic [SUM_W-1:0]      sum;
   logic [SUM_W-1:0]      shifted;
   logic [DATA_WIDTH-1:0] sat;

   // A stalled output freezes every stage; clear blocks new samples.
   assign en      = !y_valid || y_ready;
   assign x_ready = en && !clear;
   assign accept  = x_valid && x_ready;

   always_comb begin
      tap_next[0] = x_data;
      for (int i = 1; i < TAPS; i++) tap_next[i] = tap[i-1];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < TAPS; i++) tap[i] <= '0;
      end else if (clear) begin
         for (int i = 0; i < TAPS; i++) tap[i] <= '0;
      end else if (accept) begin
         for (int i = 0; i < TAPS; i++) tap[i] <= tap_next[i];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < TAPS; i++) coef[i] <= COEF_WIDTH'(1);
      end else if (coef_wr && (int'(coef_idx) < TAPS)) begin
         coef[coef_idx] <= coef_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < TAPS; i++) prod[i] <= '0;
         s1_valid <= 1'b0;
      end else if (clear) begin
         s1_valid <= 1'b0;
      end else if (en) begin
         s1_valid <= accept;
         if (accept) begin
            for (int i = 0; i < TAPS; i++)
               prod[i] <= PROD_W'(coef[i]) * PROD_W'(tap_next[i]);
         end
      end
   end

   always_comb begin
      sum = '0;
      for (int i = 0; i < TAPS; i++) sum = sum + SUM_W'(prod[i]);
      shifted = sum >> SHIFT;
      sat     = (shifted > SAT_MAX) ? {DATA_WIDTH{1'b1}} : shifted[DATA_WIDTH-1:0];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         y_data  <= '0;
         y_valid <= 1'b0;
      end else if (clear) begin
         y_valid <= 1'b0;
      end else if (en) begin
         y_data  <= sat;
         y_valid <= s1_valid;
      end
   end

`ifdef FIR_PARITY_CHECK_EN
   // Output parity is regenerated from the saturated result, not carried.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         y_parity <= 1'b0;
      end else if (!clear && en) begin
         y_parity <= ^sat;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         parity_err <= 1'b0;
      end else if (accept && (x_parity != ^x_data)) begin
         parity_err <= 1'b1;
      end
   end
`else
   logic s1_parity;

   // Parity of the newest contributing sample travels alongside the data.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_parity <= 1'b0;
         y_parity  <= 1'b0;
      end else if (!clear && en) begin
         if (accept) s1_parity <= x_parity;
         y_parity <= s1_parity;
      end
   end

   assign parity_err = 1'b0;
`endif

endmodule
